mips_register_file: RTL and testbench

- General-purpose register file for the single-cycle MIPS datapath.
- Provides two combinational read ports (rs/rt operands) and one synchronous write port (rd/rt writeback).
- Register 0 is hardwired to zero per MIPS convention.
- Sits between instruction decode and the ALU/writeback mux.

---
 rtl/mips_register_file.sv | 75 +++++++
 tb/tb_mips_register_file.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_register_file.sv
// Two-read, one-write general-purpose register file for the single-cycle MIPS datapath.
// Register 0 reads as zero; optional same-cycle write forwarding onto the read ports.
module mips_register_file #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGISTERS = 32,
    parameter bit BYPASS        = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            readRegister1,
    input  logic [4:0]            readRegister2,
    input  logic [4:0]            writeRegister,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  writeEnable,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2
);

    localparam int MAX_REGS = 32;

    // Storage spans the whole 5-bit space; entries past NUM_REGISTERS stay at zero.
    logic [MAX_REGS-1:0][DATA_WIDTH-1:0] regs_q;
    logic [MAX_REGS-1:0][DATA_WIDTH-1:0] regs_d;
    logic                                wr_valid;

    function automatic logic addr_valid(input logic [4:0] a);
        return (a != 5'd0) && (int'(a) < NUM_REGISTERS);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic [4:0]                          a,
        input logic [MAX_REGS-1:0][DATA_WIDTH-1:0] regs,
        input logic                                live,
        input logic                                fwd,
        input logic [4:0]                          waddr,
        input logic [DATA_WIDTH-1:0]               wdata
    );
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        if (live && addr_valid(a)) begin
            v = regs[a];
            if (BYPASS && fwd && (waddr == a)) begin
                v = wdata;
            end
        end
        return v;
    endfunction

    always_comb begin
        wr_valid = rst && writeEnable && addr_valid(writeRegister);
        regs_d   = regs_q;
        for (int i = 1; i < MAX_REGS; i++) begin
            if (wr_valid && (writeRegister == 5'(i))) begin
                regs_d[i] = writeData;
            end
        end
        regs_d[0] = '0;
    end

    always_comb begin
        readData1 = read_port(readRegister1, regs_q, rst, wr_valid,
                              writeRegister, writeData);
        readData2 = read_port(readRegister2, regs_q, rst, wr_valid,
                              writeRegister, writeData);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: tb/tb_mips_register_file.sv
// Bench for mips_register_file: a 32-entry non-forwarding instance and a 16-entry
// forwarding instance share stimulus and are checked against array-based models.
module tb_mips_register_file;

    logic        clk;
    logic        rst;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        we;
    logic [31:0] rd1_a;
    logic [31:0] rd2_a;
    logic [31:0] rd1_b;
    logic [31:0] rd2_b;

    logic [31:0] mem_a [32];
    logic [31:0] mem_b [32];

    int vectors;
    int miscompares;

    wire [127:0] got = {rd1_a, rd2_a, rd1_b, rd2_b};

    mips_register_file #(
        .DATA_WIDTH(32), .NUM_REGISTERS(32), .BYPASS(1'b0)
    ) u_a (
        .clk(clk), .rst(rst),
        .readRegister1(ra1), .readRegister2(ra2),
        .writeRegister(wa), .writeData(wd), .writeEnable(we),
        .readData1(rd1_a), .readData2(rd2_a)
    );

    mips_register_file #(
        .DATA_WIDTH(32), .NUM_REGISTERS(16), .BYPASS(1'b1)
    ) u_b (
        .clk(clk), .rst(rst),
        .readRegister1(ra1), .readRegister2(ra2),
        .writeRegister(wa), .writeData(wd), .writeEnable(we),
        .readData1(rd1_b), .readData2(rd2_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] exp_rd(input bit b, input logic [4:0] a);
        int n;
        n = b ? 16 : 32;
        if (!rst || a == 5'd0 || int'(a) >= n) return 32'd0;
        if (b && we && wa == a) return wd;
        return b ? mem_b[a] : mem_a[a];
    endfunction

    function automatic logic [127:0] exp_all();
        return {exp_rd(1'b0, ra1), exp_rd(1'b0, ra2),
                exp_rd(1'b1, ra1), exp_rd(1'b1, ra2)};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = 32'd0;
            mem_b[i] = 32'd0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst && we && wa != 5'd0) begin
            mem_a[wa] = wd;
            if (wa < 5'd16) mem_b[wa] = wd;
        end
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_clear();
        #10;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            #1;
            vectors++;
            if (got !== 128'd0) begin
                miscompares++;
                $display("FAIL reset_read addr=%0d got=%h exp=0", i, got);
            end
        end
        we = 1'b1; wa = 5'd2; wd = 32'hAABBCCDD;
        tick();
        we = 1'b0; ra1 = 5'd2; ra2 = 5'd2;
        #1;
        vectors++;
        if (got !== 128'd0) begin
            miscompares++;
            $display("FAIL reset_write_block got=%h exp=0", got);
        end
    endtask

    task automatic test_write_hold();
        rst = 1'b1;
        we = 1'b1; wa = 5'd2; wd = 32'hAABBCCDD;
        tick();
        wd = 32'h11223344;
        tick();
        we = 1'b0; ra1 = 5'd0; ra2 = 5'd2;
        #1;
        vectors++;
        if (got !== {32'd0, 32'h11223344, 32'd0, 32'h11223344}) begin
            miscompares++;
            $display("FAIL write_hold got=%h exp=%h", got,
                     {32'd0, 32'h11223344, 32'd0, 32'h11223344});
        end
    endtask

    task automatic test_reg0();
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
        ra1 = 5'd0; ra2 = 5'd0;
        #1;
        vectors++;
        if (got !== 128'd0) begin
            miscompares++;
            $display("FAIL reg0_bypass got=%h exp=0", got);
        end
        tick();
        we = 1'b0;
        #1;
        vectors++;
        if (got !== 128'd0) begin
            miscompares++;
            $display("FAIL reg0_write got=%h exp=0", got);
        end
    endtask

    task automatic test_collision();
        logic [127:0] want;
        we = 1'b1; wa = 5'd5; wd = 32'h12345678;
        tick();
        wd = 32'hDEADBEEF; ra1 = 5'd5; ra2 = 5'd5;
        #1;
        want = {32'h12345678, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF};
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL collision_pre got=%h exp=%h", got, want);
        end
        tick();
        we = 1'b0;
        #1;
        want = {4{32'hDEADBEEF}};
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL collision_post got=%h exp=%h", got, want);
        end
    endtask

    task automatic test_fill_and_reset();
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; wa = 5'(i); wd = 32'h100 + 32'(i);
            tick();
        end
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 32; j++) begin
                ra1 = 5'(i); ra2 = 5'(j);
                #1;
                vectors++;
                if (got !== exp_all()) begin
                    miscompares++;
                    $display("FAIL fill_pair %0d/%0d got=%h exp=%h",
                             i, j, got, exp_all());
                end
            end
        end
        tick();
        ra1 = 5'd9; ra2 = 5'd3;
        #1;
        rst = 1'b0;
        model_clear();
        #1;
        vectors++;
        if (got !== 128'd0) begin
            miscompares++;
            $display("FAIL async_reset got=%h exp=0", got);
        end
        we = 1'b1; wa = 5'd7; wd = 32'h77777777;
        tick();
        we = 1'b0;
        #1;
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(i);
            #1;
            vectors++;
            if (got !== 128'd0) begin
                miscompares++;
                $display("FAIL post_reset addr=%0d got=%h exp=0", i, got);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [127:0] want;
        we = 1'b1; wa = 5'd4; wd = 32'h00004444;
        tick();
        wa = 5'd20; wd = 32'h0000CAFE;
        tick();
        we = 1'b0; ra1 = 5'd20; ra2 = 5'd4;
        #1;
        want = {32'h0000CAFE, 32'h00004444, 32'd0, 32'h00004444};
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL out_of_range got=%h exp=%h", got, want);
        end
        we = 1'b1; wa = 5'd20; wd = 32'h0BAD0BAD;
        #1;
        want = {32'h0000CAFE, 32'h00004444, 32'd0, 32'h00004444};
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL oor_no_bypass got=%h exp=%h", got, want);
        end
        tick();
        we = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 24) == 0) begin
                rst = 1'b0;
                model_clear();
            end else begin
                rst = 1'b1;
            end
            ra1 = 5'($urandom_range(0, 31));
            ra2 = 5'($urandom_range(0, 31));
            we  = ($urandom_range(0, 3) != 0);
            wa  = ($urandom_range(0, 2) == 0) ? ra1 : 5'($urandom_range(0, 31));
            wd  = $urandom;
            #1;
            vectors++;
            if (got !== exp_all()) begin
                miscompares++;
                $display("FAIL random_pre k=%0d got=%h exp=%h",
                         k, got, exp_all());
            end
            tick();
            vectors++;
            if (got !== exp_all()) begin
                miscompares++;
                $display("FAIL random_post k=%0d got=%h exp=%h",
                         k, got, exp_all());
            end
        end
        we = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b0;
        ra1 = '0; ra2 = '0; wa = '0; wd = '0; we = 1'b0;
        model_clear();
        #2;
        test_reset();
        test_write_hold();
        test_reg0();
        test_collision();
        test_fill_and_reset();
        test_out_of_range();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
